// File: rtl/seg7_scan_reader.sv
// ============================================================================
// Module   : seg7_scan_reader
// Purpose  : Samples a scanned 4-digit 7-segment bus, debounces each digit
//            dwell, decodes the patterns to hex and emits one frame per scan.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_reader #(
   parameter int STABLE_CYC = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  i_segin,
   input  logic [3:0]  i_digsel,
   output logic [15:0] o_digits,
   output logic [3:0]  o_dp,
   output logic        o_valid,
   output logic        o_err
);

   localparam logic [7:0] c_cnt_max = 8'(STABLE_CYC - 1);

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_COUNT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   logic [7:0]  r_seg_s1;
   logic [7:0]  r_seg_s2;
   logic [3:0]  r_dig_s1;
   logic [3:0]  r_dig_s2;
   logic [7:0]  r_cnt;
   state_t      r_state;
   logic [15:0] r_shadow;
   logic [3:0]  r_sh_dp;
   logic [3:0]  r_cap;
   logic        r_ferr;

   logic        w_chg;
   logic        w_onehot;
   logic [7:0]  w_cnt_nxt;
   logic        w_accept;
   logic        w_frame_done;
   logic [3:0]  w_nib;
   logic        w_bad;
   logic [3:0]  w_cap_base;
   logic        w_ferr_base;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg_s1 <= 8'h00;
         r_seg_s2 <= 8'h00;
         r_dig_s1 <= 4'h0;
         r_dig_s2 <= 4'h0;
      end else begin
         r_seg_s1 <= i_segin;
         r_seg_s2 <= r_seg_s1;
         r_dig_s1 <= i_digsel;
         r_dig_s2 <= r_dig_s1;
      end
   end

   // Stability is judged on the sample entering s2 against the one it replaces.
   assign w_chg     = (r_seg_s1 != r_seg_s2) || (r_dig_s1 != r_dig_s2);
   assign w_onehot  = (r_dig_s1 != 4'h0) && ((r_dig_s1 & (r_dig_s1 - 4'd1)) == 4'h0);
   assign w_cnt_nxt = w_chg ? 8'd0 :
                      ((r_cnt == c_cnt_max) ? r_cnt : (r_cnt + 8'd1));
   assign w_accept  = (r_state == ST_COUNT) && !w_chg && w_onehot &&
                      (w_cnt_nxt == c_cnt_max);

   assign w_frame_done = (r_cap == 4'hF);
   assign w_cap_base   = w_frame_done ? 4'h0 : r_cap;
   assign w_ferr_base  = w_frame_done ? 1'b0 : r_ferr;

   always_comb begin
      w_nib = 4'h0;
      w_bad = 1'b0;
      case (r_seg_s2[6:0])
         7'h3F: w_nib = 4'h0;
         7'h06: w_nib = 4'h1;
         7'h5B: w_nib = 4'h2;
         7'h4F: w_nib = 4'h3;
         7'h66: w_nib = 4'h4;
         7'h6D: w_nib = 4'h5;
         7'h7D: w_nib = 4'h6;
         7'h07: w_nib = 4'h7;
         7'h7F: w_nib = 4'h8;
         7'h6F: w_nib = 4'h9;
         7'h77: w_nib = 4'hA;
         7'h7C: w_nib = 4'hB;
         7'h39: w_nib = 4'hC;
         7'h5E: w_nib = 4'hD;
         7'h79: w_nib = 4'hE;
         7'h71: w_nib = 4'hF;
         default: begin
            w_nib = 4'h0;
            w_bad = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_WAIT;
         r_cnt    <= 8'd0;
         r_shadow <= 16'h0000;
         r_sh_dp  <= 4'h0;
         r_cap    <= 4'h0;
         r_ferr   <= 1'b0;
         o_digits <= 16'h0000;
         o_dp     <= 4'h0;
         o_valid  <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;

         case (r_state)
            ST_WAIT: begin
               if (w_onehot) r_state <= ST_COUNT;
            end
            ST_COUNT: begin
               if (!w_onehot)     r_state <= ST_WAIT;
               else if (w_accept) r_state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (w_chg) r_state <= w_onehot ? ST_COUNT : ST_WAIT;
            end
            default: r_state <= ST_WAIT;
         endcase

         for (int i = 0; i < 4; i++) begin
            if (w_accept && r_dig_s2[i]) begin
               r_shadow[4*i +: 4] <= w_nib;
               r_sh_dp[i]         <= r_seg_s2[7];
            end
         end

         // Clearing before OR-ing lets a capture on the completion edge open the next frame.
         r_cap  <= w_cap_base | (w_accept ? r_dig_s2 : 4'h0);
         r_ferr <= w_ferr_base | (w_accept & w_bad);

         o_valid <= w_frame_done;
         if (w_frame_done) begin
            o_digits <= r_shadow;
            o_dp     <= r_sh_dp;
            o_err    <= r_ferr;
         end
      end
   end

endmodule

`default_nettype wire
